// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed seven-segment display driver.
// Scans NUM_DIGITS hex nibbles onto a shared-segment display, one digit per
// slot of REFRESH_CNT cycles. Each slot begins with DEAD_CYCLES of darkness to
// suppress ghosting. A shadow copy of the inputs, taken once per frame,
// prevents tearing. All outputs are registered.
module seg7_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_CNT = 100000,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int unsigned CntW = $clog2(REFRESH_CNT);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CNT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
    localparam logic Inv = (ACTIVE_LOW != 0);

    logic [CntW-1:0]         r_cnt;
    logic [IdxW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_loaded;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [6:0]            w_dec;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic                  w_frame_start;

    assign w_slot_end  = (r_cnt == CntLast);
    assign w_frame_end = w_slot_end && (r_idx == IdxLast);

    // Slot counter and digit index; idx advances when the slot counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow capture at end of frame only; reset blanks everything so the
    // first frame is dark. r_loaded gates frame_tick until the first capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '1;
            r_loaded   <= 1'b0;
        end else if (w_frame_end) begin
            r_sh_value <= value;
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank;
            r_loaded   <= 1'b1;
        end
    end

    // Select the current digit's shadow fields and build its one-hot enable.
    always_comb begin
        w_nib       = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_idx == IdxW'(i)) begin
                w_nib       = r_sh_value[4*i +: 4];
                w_dp_sel    = r_sh_dp[i];
                w_blank_sel = r_sh_blank[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Hex to segment decode, bit order gfedcba, active-high.
    always_comb begin
        w_dec = 7'h00;
        unique case (w_nib)
            4'h0: w_dec = 7'h3F;
            4'h1: w_dec = 7'h06;
            4'h2: w_dec = 7'h5B;
            4'h3: w_dec = 7'h4F;
            4'h4: w_dec = 7'h66;
            4'h5: w_dec = 7'h6D;
            4'h6: w_dec = 7'h7D;
            4'h7: w_dec = 7'h07;
            4'h8: w_dec = 7'h7F;
            4'h9: w_dec = 7'h6F;
            4'hA: w_dec = 7'h77;
            4'hB: w_dec = 7'h7C;
            4'hC: w_dec = 7'h39;
            4'hD: w_dec = 7'h5E;
            4'hE: w_dec = 7'h79;
            4'hF: w_dec = 7'h71;
        endcase
    end

    // Active-high next outputs: dark during dead time or when digit blanked.
    always_comb begin
        w_lit         = (32'(r_cnt) >= DEAD_CYCLES) && !w_blank_sel;
        w_an          = w_lit ? w_onehot : '0;
        w_seg         = w_lit ? w_dec : 7'h00;
        w_dp          = w_lit && w_dp_sel;
        w_frame_start = r_loaded && (r_cnt == '0) && (r_idx == '0);
    end

    // Output register with polarity applied; reset forces inactive levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= {NUM_DIGITS{Inv}};
            r_seg        <= {7{Inv}};
            r_dp         <= Inv;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an ^ {NUM_DIGITS{Inv}};
            r_seg        <= w_seg ^ {7{Inv}};
            r_dp         <= w_dp ^ Inv;
            r_frame_tick <= w_frame_start;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
